// File: rtl/scan_pkg.sv
// Shared constants and types for the 15 kHz -> 31 kHz scan doubler.
// Timing defaults match the Galaga-family 384x264 raster.
package scan_pkg;
   localparam int DEF_DW       = 8;
   localparam int DEF_AW       = 9;
   localparam int DEF_LINE_LEN = 384;
   localparam int DEF_ACTIVE   = 288;
   localparam int DEF_HS_START = 296;
   localparam int DEF_HS_WIDTH = 46;

   typedef enum logic {
      MODE_DOUBLE = 1'b0,
      MODE_BYPASS = 1'b1
   } mode_t;
endpackage

// File: rtl/line_buffer.sv
// Simple dual-port line RAM: one write port, one registered read port.
// The address MSB selects the ping-pong bank.
module line_buffer #(
   parameter int DW = 8,
   parameter int AW = 9
) (
   input  logic          clk_sys,
   input  logic          we,
   input  logic [AW:0]   waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW:0]   raddr,
   output logic [DW-1:0] rdata
);
   logic [DW-1:0] mem [2**(AW+1)];

   // No reset: this has to map onto block RAM.
   always_ff @(posedge clk_sys) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end
endmodule

// File: rtl/scan_doubler.sv
// Scan doubler: each input line is written to one bank of a ping-pong buffer
// and replayed twice at double rate from the other bank; EN=0 selects bypass.
//
// state       | meaning
// ------------+------------------------------------------------------------
// MODE_DOUBLE | outputs come from the buffer replay at twice the line rate
// MODE_BYPASS | outputs are the 15 kHz inputs registered on CE_PIX
module scan_doubler
   import scan_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int AW       = DEF_AW,
   parameter int LINE_LEN = DEF_LINE_LEN,
   parameter int ACTIVE   = DEF_ACTIVE,
   parameter int HS_START = DEF_HS_START,
   parameter int HS_WIDTH = DEF_HS_WIDTH
) (
   input  logic          CLK,
   input  logic          RST_N,
   input  logic          CE_PIX,
   input  logic          EN,
   input  logic [DW-1:0] RGB_IN,
   input  logic          HBLK_IN,
   input  logic          VBLK_IN,
   input  logic          HSYN_IN,
   input  logic          VSYN_IN,
   output logic [DW-1:0] RGB_OUT,
   output logic          HBLK_OUT,
   output logic          VBLK_OUT,
   output logic          HSYN_OUT,
   output logic          VSYN_OUT
);
   localparam logic [AW-1:0] ACTIVE_W = AW'(ACTIVE);
   localparam logic [AW-1:0] LAST_H   = AW'(LINE_LEN - 1);
   localparam logic [AW-1:0] HS_BEG_W = AW'(HS_START);
   localparam logic [AW-1:0] HS_END_W = AW'(HS_START + HS_WIDTH);
   localparam logic [AW-1:0] ONE_W    = AW'(1);

   logic          ls;
   logic          hblk_prev_q, hblk_prev_d;
   logic          vblk_reg_q, vblk_reg_d;
   logic          vsyn_reg_q, vsyn_reg_d;
   logic          wbank_q, wbank_d;
   logic [AW-1:0] wcnt_q, wcnt_d;
   logic [AW-1:0] out_h_q, out_h_d;
   logic          hblk_s1_q, hblk_s1_d;
   logic          hsyn_s1_q, hsyn_s1_d;
   mode_t         mode_q, mode_d;
   logic [DW-1:0] rgb_out_q, rgb_out_d;
   logic          hblk_out_q, hblk_out_d;
   logic          vblk_out_q, vblk_out_d;
   logic          hsyn_out_q, hsyn_out_d;
   logic          vsyn_out_q, vsyn_out_d;

   logic          buf_we;
   logic [AW:0]   buf_waddr;
   logic [AW:0]   buf_raddr;
   logic [DW-1:0] buf_rdata;

   line_buffer #(
      .DW (DW),
      .AW (AW)
   ) u_line_buffer (
      .clk_sys (CLK),
      .we      (buf_we),
      .waddr   (buf_waddr),
      .wdata   (RGB_IN),
      .raddr   (buf_raddr),
      .rdata   (buf_rdata)
   );

   always_comb begin
      ls          = CE_PIX & ~HBLK_IN & hblk_prev_q;
      hblk_prev_d = CE_PIX ? HBLK_IN : hblk_prev_q;
      vblk_reg_d  = CE_PIX ? VBLK_IN : vblk_reg_q;
      vsyn_reg_d  = CE_PIX ? VSYN_IN : vsyn_reg_q;

      // Write side: the line-start pixel lands at address 0 of the fresh bank.
      wbank_d   = wbank_q;
      wcnt_d    = wcnt_q;
      buf_we    = 1'b0;
      buf_waddr = {wbank_q, wcnt_q};
      if (ls) begin
         wbank_d   = ~wbank_q;
         wcnt_d    = ONE_W;
         buf_we    = RST_N;
         buf_waddr = {~wbank_q, {AW{1'b0}}};
      end else if (CE_PIX && !HBLK_IN && (wcnt_q < ACTIVE_W)) begin
         wcnt_d    = wcnt_q + ONE_W;
         buf_we    = RST_N;
      end

      if (ls || (out_h_q == LAST_H)) begin
         out_h_d = '0;
      end else begin
         out_h_d = out_h_q + ONE_W;
      end
      buf_raddr = {~wbank_q, out_h_q};
      hblk_s1_d = (out_h_q >= ACTIVE_W);
      hsyn_s1_d = ~((out_h_q >= HS_BEG_W) && (out_h_q < HS_END_W));

      mode_d = mode_q;
      if (ls) begin
         mode_d = EN ? MODE_DOUBLE : MODE_BYPASS;
      end

      rgb_out_d  = rgb_out_q;
      hblk_out_d = hblk_out_q;
      vblk_out_d = vblk_out_q;
      hsyn_out_d = hsyn_out_q;
      vsyn_out_d = vsyn_out_q;
      if (mode_d == MODE_BYPASS) begin
         if (CE_PIX) begin
            rgb_out_d  = (HBLK_IN || VBLK_IN) ? '0 : RGB_IN;
            hblk_out_d = HBLK_IN;
            vblk_out_d = VBLK_IN;
            hsyn_out_d = HSYN_IN;
            vsyn_out_d = VSYN_IN;
         end
      end else begin
         // Vertical state of the line just finished, held for both replays.
         if (ls) begin
            vblk_out_d = vblk_reg_q;
            vsyn_out_d = vsyn_reg_q;
         end
         hblk_out_d = hblk_s1_q;
         hsyn_out_d = hsyn_s1_q;
         rgb_out_d  = (hblk_s1_q || vblk_out_d) ? '0 : buf_rdata;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hblk_prev_q <= 1'b0;
         vblk_reg_q  <= 1'b1;
         vsyn_reg_q  <= 1'b1;
         wbank_q     <= 1'b0;
         wcnt_q      <= '0;
         out_h_q     <= '0;
         hblk_s1_q   <= 1'b1;
         hsyn_s1_q   <= 1'b1;
         mode_q      <= MODE_DOUBLE;
         rgb_out_q   <= '0;
         hblk_out_q  <= 1'b1;
         vblk_out_q  <= 1'b1;
         hsyn_out_q  <= 1'b1;
         vsyn_out_q  <= 1'b1;
      end else begin
         hblk_prev_q <= hblk_prev_d;
         vblk_reg_q  <= vblk_reg_d;
         vsyn_reg_q  <= vsyn_reg_d;
         wbank_q     <= wbank_d;
         wcnt_q      <= wcnt_d;
         out_h_q     <= out_h_d;
         hblk_s1_q   <= hblk_s1_d;
         hsyn_s1_q   <= hsyn_s1_d;
         mode_q      <= mode_d;
         rgb_out_q   <= rgb_out_d;
         hblk_out_q  <= hblk_out_d;
         vblk_out_q  <= vblk_out_d;
         hsyn_out_q  <= hsyn_out_d;
         vsyn_out_q  <= vsyn_out_d;
      end
   end

   assign RGB_OUT  = rgb_out_q;
   assign HBLK_OUT = hblk_out_q;
   assign VBLK_OUT = vblk_out_q;
   assign HSYN_OUT = hsyn_out_q;
   assign VSYN_OUT = vsyn_out_q;
endmodule
